// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) arithmetic blocks: controller states,
// the AES reduction polynomial and a generic multiply-by-x helper.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_state_t;

  // Low eight bits of x^8 + x^4 + x^3 + x + 1; the x^8 term is implied.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Multiply a field element by x and reduce it. The element lives in the
  // low 'width' bits of 'a' and the reduction polynomial (without its
  // leading term) in the low 'width' bits of 'poly'.
  function automatic logic [63:0] xtime(input logic [63:0] a,
                                        input int width,
                                        input logic [63:0] poly);
    logic [63:0] mask;
    logic        msb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    msb  = ((a >> (width - 1)) & 64'd1) != 64'd0;
    return ((a << 1) & mask) ^ (msb ? (poly & mask) : 64'd0);
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational multiply-by-x step in GF(2^WIDTH): shift left by one and
// fold the overflowing x^WIDTH term back in with the reduction polynomial.
module gf_xtime
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // The shifted-out MSB is the coefficient of x^WIDTH, replaced by POLY.
  assign y = {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/gf_mul_acc.sv
// Bit-serial GF(2^WIDTH) multiply-accumulate unit with valid/ready handshakes.
// Optional macro GF_MUL_ACC_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always spending WIDTH cycles.
module gf_mul_acc
  import gf_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] poly1,
  input  logic [WIDTH-1:0] poly2,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] GFmac_result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  gf_state_t        state, state_next;
  logic [WIDTH-1:0] a, b, p, acc;
  logic [WIDTH-1:0] a_next, b_next, p_next;
  logic [CW-1:0]    count;
  logic             acc_sel;
  logic             last_step;

  gf_xtime #(
    .WIDTH(WIDTH),
    .POLY (POLY)
  ) u_xtime (
    .a(a),
    .y(a_next)
  );

  assign b_next = b >> 1;
  assign p_next = b[0] ? (p ^ a) : p;

`ifdef GF_MUL_ACC_EARLY_EXIT_EN
  assign last_step = (count == LAST_COUNT) || (b_next == '0);
`else
  assign last_step = (count == LAST_COUNT);
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept, iterate, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-and-add datapath; the result register is loaded on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a            <= '0;
      b            <= '0;
      p            <= '0;
      count        <= '0;
      acc_sel      <= 1'b0;
      GFmac_result <= '0;
    end else if (state == IDLE && in_valid) begin
      a       <= poly1;
      b       <= poly2;
      p       <= '0;
      count   <= '0;
      acc_sel <= acc_en;
    end else if (state == BUSY) begin
      a     <= a_next;
      b     <= b_next;
      p     <= p_next;
      count <= count + CW'(1);
      if (last_step) GFmac_result <= p_next ^ (acc_sel ? acc : '0);
    end
  end

  // Accumulator: clear always wins over the write-back at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     acc <= '0;
    else if (acc_clr)                               acc <= '0;
    else if (state == DONE && out_ready && acc_sel) acc <= GFmac_result;
  end

endmodule

// File: tb/tb_gf_mul_acc.sv
// Self-checking bench for gf_mul_acc (WIDTH=8, AES polynomial) against a
// carry-less multiply / polynomial-division reference model.
module tb_gf_mul_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] poly1 = '0;
  logic [7:0] poly2 = '0;
  logic       acc_en = 1'b0;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] GFmac_result;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_acc = '0;

  always #5 clk = ~clk;

  gf_mul_acc #(.WIDTH(8), .POLY(8'h1B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .poly1       (poly1),
    .poly2       (poly2),
    .acc_en      (acc_en),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .GFmac_result(GFmac_result)
  );

  // Reference product: full carry-less multiply, then divide by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (y[i]) prod = prod ^ (16'(x) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
    return prod[7:0];
  endfunction

  // Expected edges from accept to out_valid.
  function automatic int exp_latency(input logic [7:0] y);
`ifdef GF_MUL_ACC_EARLY_EXIT_EN
    int top;
    top = 0;
    for (int i = 0; i < 8; i++) if (y[i]) top = i + 1;
    return (top < 1) ? 1 : top;
`else
    return (y === y) ? 8 : 8;
`endif
  endfunction

  // Expected result of one operation; updates the model accumulator.
  function automatic logic [7:0] model_op(input logic [7:0] x, input logic [7:0] y,
                                          input logic en, input logic clr_on_done);
    logic [7:0] r;
    r = gf_ref(x, y) ^ (en ? model_acc : 8'h00);
    if (clr_on_done)  model_acc = 8'h00;
    else if (en)      model_acc = r;
    return r;
  endfunction

  // Drive one full transaction; returns the result seen and the latency.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic en,
                       input int hold, input logic clr_on_done,
                       output logic [7:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    poly1 = x; poly2 = y; acc_en = en; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    res = GFmac_result;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1; acc_clr = clr_on_done;
    @(posedge clk); #1;
    out_ready = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic pulse_clear();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    model_acc = 8'h00;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (GFmac_result !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_result got=%h exp=00", GFmac_result); end
  endtask

  task automatic test_basic();
    logic [7:0] r; int lat;
    do_op(8'h57, 8'h83, 1'b0, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'hC1) begin n_fail++; $display("[TB] FAIL basic_57x83 got=%h exp=c1", r); end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("[TB] FAIL basic_latency got=%0d exp=8", lat); end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL basic_back_to_idle got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] r, e; int lat;
    pulse_clear();
    e = model_op(8'h57, 8'h13, 1'b1, 1'b0);
    do_op(8'h57, 8'h13, 1'b1, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'hFE || e !== 8'hFE) begin n_fail++; $display("[TB] FAIL acc_first got=%h exp=fe", r); end
    e = model_op(8'h57, 8'h83, 1'b1, 1'b0);
    do_op(8'h57, 8'h83, 1'b1, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'h3F || e !== 8'h3F) begin n_fail++; $display("[TB] FAIL acc_second got=%h exp=3f", r); end
    e = model_op(8'h00, 8'h00, 1'b1, 1'b0);
    do_op(8'h00, 8'h00, 1'b1, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'h3F) begin n_fail++; $display("[TB] FAIL acc_readback got=%h exp=3f", r); end
  endtask

  task automatic test_hold();
    logic [7:0] held; int lat;
    poly1 = 8'hCA; poly2 = 8'h53; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== exp_latency(8'h53)) begin n_fail++; $display("[TB] FAIL hold_latency got=%0d exp=%0d", lat, exp_latency(8'h53)); end
    held = GFmac_result;
    n_checks++;
    if (held !== gf_ref(8'hCA, 8'h53)) begin n_fail++; $display("[TB] FAIL hold_value got=%h exp=%h", held, gf_ref(8'hCA, 8'h53)); end
    poly1 = 8'h11; poly2 = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (GFmac_result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL hold_stable cyc=%0d got res=%h ov=%b ir=%b exp res=%h ov=1 ir=0",
                 i, GFmac_result, out_valid, in_ready, held);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hold_release got ov=%b ir=%b exp 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_no_accept got ir=%b exp=1", in_ready); end
  endtask

  task automatic test_clr_handshake();
    logic [7:0] r, e; int lat;
    e = model_op(8'h3C, 8'hA5, 1'b1, 1'b0);
    do_op(8'h3C, 8'hA5, 1'b1, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== e) begin n_fail++; $display("[TB] FAIL clr_preload got=%h exp=%h", r, e); end
    e = model_op(8'h6D, 8'h19, 1'b1, 1'b1);
    do_op(8'h6D, 8'h19, 1'b1, 2, 1'b1, r, lat);
    n_checks++;
    if (r !== e) begin n_fail++; $display("[TB] FAIL clr_second got=%h exp=%h", r, e); end
    e = model_op(8'h02, 8'h87, 1'b1, 1'b0);
    do_op(8'h02, 8'h87, 1'b1, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'h15 || e !== 8'h15) begin n_fail++; $display("[TB] FAIL clr_wins got=%h exp=15", r); end
  endtask

  task automatic test_abort();
    logic [7:0] r; int lat;
    poly1 = 8'h57; poly2 = 8'h83; acc_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || GFmac_result !== 8'h00) begin
      n_fail++; $display("[TB] FAIL abort_async got ir=%b ov=%b res=%h exp 1/0/00", in_ready, out_valid, GFmac_result);
    end
    model_acc = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h57, 8'h83, 1'b0, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'hC1) begin n_fail++; $display("[TB] FAIL abort_fresh got=%h exp=c1", r); end
    do_op(8'h00, 8'h00, 1'b1, 0, 1'b0, r, lat);
    n_checks++;
    if (r !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_acc_lost got=%h exp=00", r); end
  endtask

  task automatic test_boundary();
    logic [7:0] r; int lat;
    logic [7:0] ys [4];
    ys[0] = 8'h01; ys[1] = 8'h00; ys[2] = 8'h80; ys[3] = 8'h04;
    for (int i = 0; i < 4; i++) begin
      do_op(8'hB7, ys[i], 1'b0, 0, 1'b0, r, lat);
      n_checks++;
      if (r !== gf_ref(8'hB7, ys[i])) begin n_fail++; $display("[TB] FAIL bound_value y=%h got=%h exp=%h", ys[i], r, gf_ref(8'hB7, ys[i])); end
      n_checks++;
      if (lat !== exp_latency(ys[i])) begin n_fail++; $display("[TB] FAIL bound_latency y=%h got=%0d exp=%0d", ys[i], lat, exp_latency(ys[i])); end
    end
  endtask

  task automatic test_random();
    logic [7:0] x, y, r, e; logic en, clr; int lat;
    for (int n = 0; n < 30; n++) begin
      x = 8'($urandom); y = 8'($urandom); en = 1'($urandom);
      clr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 4) == 0) pulse_clear();
      e = model_op(x, y, en, clr);
      do_op(x, y, en, $urandom_range(0, 3), clr, r, lat);
      n_checks++;
      if (r !== e) begin n_fail++; $display("[TB] FAIL rand_value %h*%h en=%b got=%h exp=%h", x, y, en, r, e); end
      n_checks++;
      if (lat !== exp_latency(y)) begin n_fail++; $display("[TB] FAIL rand_latency y=%h got=%0d exp=%0d", y, lat, exp_latency(y)); end
    end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_accumulate();
    test_hold();
    test_clr_handshake();
    test_abort();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
